// File: rtl/multicycle_control_fsm.sv
// Multicycle ARM control unit: sequences fetch/decode/execute steps over a
// shared memory and single ALU, holds NZCV and the per-instruction condition.
module multicycle_control_fsm #(
    parameter int unsigned NUM_STATES = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    localparam int unsigned StateW = $clog2(NUM_STATES);

    typedef enum logic [StateW-1:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemAdr = 4'd2,
        StMemRd  = 4'd3,
        StMemWb  = 4'd4,
        StMemWr  = 4'd5,
        StExecR  = 4'd6,
        StExecI  = 4'd7,
        StAluWb  = 4'd8,
        StBranch = 4'd9
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] flags_q;
    logic       cond_ex_q;

    logic [3:0] cmd;
    logic       is_add, is_sub, is_and, is_orr, is_cmp, is_known;
    logic [1:0] flag_w;
    logic [1:0] alu_dec;
    logic       cond_met;
    logic       rd_is_pc;
    logic       n_f, z_f, c_f, v_f;

    assign cmd      = Funct[4:1];
    assign is_add   = (cmd == 4'b0100);
    assign is_sub   = (cmd == 4'b0010);
    assign is_and   = (cmd == 4'b0000);
    assign is_orr   = (cmd == 4'b1100);
    assign is_cmp   = (cmd == 4'b1010);
    assign is_known = is_add | is_sub | is_and | is_orr | is_cmp;
    assign rd_is_pc = (Rd == 4'd15);

    // Unrecognised cmds act as ADD and never touch the flags; CMP always sets NZCV.
    assign flag_w[1] = (Funct[0] & is_known) | is_cmp;
    assign flag_w[0] = (Funct[0] & (is_add | is_sub | is_cmp)) | is_cmp;

    assign {n_f, z_f, c_f, v_f} = flags_q;

    // ALU operation decoded from cmd for the execute states.
    always_comb begin
        alu_dec = 2'b00;
        if (is_sub || is_cmp) alu_dec = 2'b01;
        else if (is_and)      alu_dec = 2'b10;
        else if (is_orr)      alu_dec = 2'b11;
    end

    // Condition check against the stored flags; 1110 and 1111 both mean always.
    always_comb begin
        cond_met = 1'b1;
        case (Cond)
            4'b0000: cond_met = z_f;
            4'b0001: cond_met = ~z_f;
            4'b0010: cond_met = c_f;
            4'b0011: cond_met = ~c_f;
            4'b0100: cond_met = n_f;
            4'b0101: cond_met = ~n_f;
            4'b0110: cond_met = v_f;
            4'b0111: cond_met = ~v_f;
            4'b1000: cond_met = c_f & ~z_f;
            4'b1001: cond_met = ~c_f | z_f;
            4'b1010: cond_met = (n_f == v_f);
            4'b1011: cond_met = (n_f != v_f);
            4'b1100: cond_met = ~z_f & (n_f == v_f);
            4'b1101: cond_met = z_f | (n_f != v_f);
            default: cond_met = 1'b1;
        endcase
    end

    // Next-state selection.
    always_comb begin
        state_d = StFetch;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                unique case (Op)
                    2'b01:   state_d = StMemAdr;
                    2'b00:   state_d = Funct[5] ? StExecI : StExecR;
                    2'b10:   state_d = StBranch;
                    default: state_d = StFetch;
                endcase
            end
            StMemAdr: state_d = Funct[0] ? StMemRd : StMemWr;
            StMemRd:  state_d = StMemWb;
            StExecR:  state_d = StAluWb;
            StExecI:  state_d = StAluWb;
            default:  state_d = StFetch;
        endcase
    end

    // State, flag register and latched condition result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StFetch;
            flags_q   <= 4'b0000;
            cond_ex_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == StDecode) cond_ex_q <= cond_met;
            if ((state_q == StExecR || state_q == StExecI) && cond_ex_q) begin
                if (flag_w[1]) flags_q[3:2] <= ALUFlags[3:2];
                if (flag_w[0]) flags_q[1:0] <= ALUFlags[1:0];
            end
        end
    end

    // Per-state datapath controls; write enables of conditional steps gated by cond_ex_q.
    always_comb begin
        PCWrite    = 1'b0;
        IRWrite    = 1'b0;
        MemWrite   = 1'b0;
        RegWrite   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        unique case (state_q)
            StFetch: begin
                IRWrite   = 1'b1;
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                PCWrite   = 1'b1;
            end
            StDecode: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            StMemAdr: ALUSrcB = 2'b01;
            StMemRd:  AdrSrc = 1'b1;
            StMemWb: begin
                ResultSrc = 2'b01;
                PCWrite   = rd_is_pc & cond_ex_q;
                RegWrite  = ~rd_is_pc & cond_ex_q;
            end
            StMemWr: begin
                AdrSrc   = 1'b1;
                MemWrite = cond_ex_q;
            end
            StExecR: ALUControl = alu_dec;
            StExecI: begin
                ALUSrcB    = 2'b01;
                ALUControl = alu_dec;
            end
            StAluWb: begin
                RegWrite = cond_ex_q & ~is_cmp & ~rd_is_pc;
                PCWrite  = cond_ex_q & ~is_cmp & rd_is_pc;
            end
            StBranch: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                PCWrite   = cond_ex_q;
            end
            default: ;
        endcase
    end

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign State  = state_q;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks instruction sequences and
// checks state, control outputs and the stored flags at each step.
module tb_multicycle_control_fsm;

    logic       clk;
    logic       reset;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic [3:0] Rd;
    logic [3:0] Cond;
    logic [3:0] ALUFlags;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA;
    logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
    logic [3:0] State;

    int checks   = 0;
    int failures = 0;

    multicycle_control_fsm dut (
        .clk        (clk),
        .reset      (reset),
        .Op         (Op),
        .Funct      (Funct),
        .Rd         (Rd),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .PCWrite    (PCWrite),
        .IRWrite    (IRWrite),
        .MemWrite   (MemWrite),
        .RegWrite   (RegWrite),
        .AdrSrc     (AdrSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ResultSrc  (ResultSrc),
        .ALUControl (ALUControl),
        .ImmSrc     (ImmSrc),
        .RegSrc     (RegSrc),
        .State      (State)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ir(input logic [1:0] op, input logic [5:0] fn, input logic [3:0] rd,
                          input logic [3:0] cd);
        Op    = op;
        Funct = fn;
        Rd    = rd;
        Cond  = cd;
    endtask

    initial begin
        reset    = 1'b1;
        ALUFlags = 4'b0000;
        set_ir(2'b01, 6'b011001, 4'd2, 4'b1110);
        tick;
        tick;
        reset = 1'b0;

        // LDR: 0,1,2,3,4,0
        chk("rst_state", State, 4'd0);
        chk("rst_flags", dut.flags_q, 4'b0000);
        chk("fetch_irw", IRWrite, 1'b1);
        chk("fetch_pcw", PCWrite, 1'b1);
        chk("fetch_srcb", ALUSrcB, 2'b10);
        chk("fetch_res", ResultSrc, 2'b10);
        tick;
        chk("ldr_s1", State, 4'd1);
        chk("dec_srca", ALUSrcA, 1'b1);
        chk("dec_rw", RegWrite, 1'b0);
        tick;
        chk("ldr_s2", State, 4'd2);
        chk("madr_srcb", ALUSrcB, 2'b01);
        chk("ldr_imm", ImmSrc, 2'b01);
        chk("ldr_regsrc", RegSrc, 2'b10);
        tick;
        chk("ldr_s3", State, 4'd3);
        chk("mrd_adr", AdrSrc, 1'b1);
        chk("mrd_mw", MemWrite, 1'b0);
        tick;
        chk("ldr_s4", State, 4'd4);
        chk("mwb_rw", RegWrite, 1'b1);
        chk("mwb_res", ResultSrc, 2'b01);
        chk("mwb_pcw", PCWrite, 1'b0);
        chk("mwb_mw", MemWrite, 1'b0);
        tick;
        chk("ldr_s0", State, 4'd0);

        // SUBS R1 with Z result
        set_ir(2'b00, 6'b000101, 4'd1, 4'b1110);
        tick;
        chk("subs_s1", State, 4'd1);
        tick;
        chk("subs_s6", State, 4'd6);
        chk("subs_aluc", ALUControl, 2'b01);
        chk("subs_srcb", ALUSrcB, 2'b00);
        ALUFlags = 4'b0100;
        tick;
        chk("subs_s8", State, 4'd8);
        chk("subs_rw", RegWrite, 1'b1);
        chk("subs_flags", dut.flags_q, 4'b0100);
        ALUFlags = 4'b1111;
        tick;
        chk("flags_ign", dut.flags_q, 4'b0100);
        ALUFlags = 4'b0000;

        // BEQ taken
        set_ir(2'b10, 6'b000000, 4'd0, 4'b0000);
        tick;
        tick;
        chk("beq_s9", State, 4'd9);
        chk("beq_pcw", PCWrite, 1'b1);
        chk("beq_srcb", ALUSrcB, 2'b01);
        tick;
        chk("beq_s0", State, 4'd0);

        // BNE not taken
        Cond = 4'b0001;
        tick;
        tick;
        chk("bne_s9", State, 4'd9);
        chk("bne_pcw", PCWrite, 1'b0);
        tick;

        // CMP, N=1
        set_ir(2'b00, 6'b010101, 4'd0, 4'b1110);
        tick;
        tick;
        chk("cmp_s6", State, 4'd6);
        chk("cmp_aluc", ALUControl, 2'b01);
        ALUFlags = 4'b1000;
        tick;
        chk("cmp_s8", State, 4'd8);
        chk("cmp_rw", RegWrite, 1'b0);
        chk("cmp_pcw", PCWrite, 1'b0);
        chk("cmp_flags", dut.flags_q, 4'b1000);
        ALUFlags = 4'b0000;
        tick;

        // ADDLT immediate, no S: LT passes with N=1 V=0
        set_ir(2'b00, 6'b101000, 4'd3, 4'b1011);
        tick;
        tick;
        chk("addlt_s7", State, 4'd7);
        chk("addlt_srcb", ALUSrcB, 2'b01);
        chk("addlt_aluc", ALUControl, 2'b00);
        ALUFlags = 4'b0101;
        tick;
        chk("addlt_rw", RegWrite, 1'b1);
        chk("addlt_flags", dut.flags_q, 4'b1000);
        ALUFlags = 4'b0000;
        tick;

        // STRNE with Z=0: store happens
        set_ir(2'b01, 6'b011000, 4'd4, 4'b0001);
        tick;
        chk("strp_dec_mw", MemWrite, 1'b0);
        tick;
        chk("strp_s2", State, 4'd2);
        chk("strp_madr_mw", MemWrite, 1'b0);
        tick;
        chk("strp_s5", State, 4'd5);
        chk("strp_mw", MemWrite, 1'b1);
        chk("strp_adr", AdrSrc, 1'b1);
        tick;
        chk("strp_s0", State, 4'd0);

        // SUBS again to set Z=1
        set_ir(2'b00, 6'b000101, 4'd1, 4'b1110);
        tick;
        tick;
        ALUFlags = 4'b0100;
        tick;
        ALUFlags = 4'b0000;
        tick;
        chk("subs2_flags", dut.flags_q, 4'b0100);

        // STRNE with Z=1: store suppressed but states still walked
        set_ir(2'b01, 6'b011000, 4'd4, 4'b0001);
        tick;
        tick;
        chk("strf_madr_mw", MemWrite, 1'b0);
        tick;
        chk("strf_s5", State, 4'd5);
        chk("strf_mw", MemWrite, 1'b0);
        tick;
        chk("strf_s0", State, 4'd0);

        // ADD to R15: writes PC, not register file
        set_ir(2'b00, 6'b001000, 4'd15, 4'b1110);
        tick;
        tick;
        chk("addpc_aluc", ALUControl, 2'b00);
        tick;
        chk("addpc_s8", State, 4'd8);
        chk("addpc_pcw", PCWrite, 1'b1);
        chk("addpc_rw", RegWrite, 1'b0);
        tick;

        // Op=11: 0,1,0 with no enables in DECODE
        set_ir(2'b11, 6'b000000, 4'd0, 4'b1110);
        tick;
        chk("nop_s1", State, 4'd1);
        chk("nop_en", {PCWrite, IRWrite, MemWrite, RegWrite}, 4'b0000);
        tick;
        chk("nop_s0", State, 4'd0);

        // Reset asserted mid-MEMRD
        set_ir(2'b01, 6'b011001, 4'd2, 4'b1110);
        tick;
        tick;
        tick;
        chk("pre_rst_s3", State, 4'd3);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_state", State, 4'd0);
        chk("arst_flags", dut.flags_q, 4'b0000);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("post_rst_s0", State, 4'd0);
        chk("post_rst_irw", IRWrite, 1'b1);
        chk("post_rst_pcw", PCWrite, 1'b1);
        tick;
        chk("post_rst_s1", State, 4'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
- Sequences a shared-memory, single-ALU ARM datapath: one instruction takes 3-5 cycles.
- Holds the NZCV flag register and evaluates the condition in DECODE.
- Drives the write enables, mux selects and ALU operation for each step.
- Replaces the single-cycle control path when the core moves to unified instruction/data memory.

Parameters:
- NUM_STATES, 10, number of FSM states (state register is 4 bits; fixed by encoding below).

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous, active-high reset.
- Op  input  2  instr[27:26] from the instruction register (IR).
- Funct  input  6  instr[25:20]: I, cmd[3:0], S/L.
- Rd  input  4  instr[15:12].
- Cond  input  4  instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU, current cycle.
- PCWrite  output  1  PC register enable.
- IRWrite  output  1  IR enable.
- MemWrite  output  1  memory write enable.
- RegWrite  output  1  register file write enable.
- AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  output  1  ALU A select: 0=RD1, 1=PC.
- ALUSrcB  output  2  ALU B select: 00=RD2, 01=ExtImm, 10=constant 4.
- ResultSrc  output  2  result select: 00=ALUOut, 01=ReadData, 10=ALU result direct.
- ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  output  2  equals Op.
- RegSrc  output  2  [0]=(Op==10), [1]=(Op==01).
- State  output  4  current state, for debug/verification.

Behaviour:
- Reset: state=FETCH(0), flags NZCV=0000, cond_ex_q=0.
- Outputs are combinational from state, cond_ex_q and the IR fields.
- Reset-mid-instruction aborts and restarts at FETCH.
- States and transitions:
  - FETCH=0 -> DECODE.
  - DECODE=1 branches on Op:
    - Op=01 -> MEMADR.
    - Op=00 and Funct[5]=0 -> EXECR.
    - Op=00 and Funct[5]=1 -> EXECI.
    - Op=10 -> BRANCH.
    - Op=11 -> FETCH (NOP).
  - MEMADR=2: Funct[0]=1 -> MEMRD=3, else MEMWR=5.
  - MEMRD=3 -> MEMWB=4 -> FETCH.
  - MEMWR=5 -> FETCH.
  - EXECR=6 / EXECI=7 -> ALUWB=8 -> FETCH.
  - BRANCH=9 -> FETCH.
- Latency: LDR 5 cycles; data-processing 4; STR 4; branch 3; Op=11 2.
- Per-state outputs (unlisted signals are 0 / 00):
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=1, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1 (unconditional).
  - DECODE: ALUSrcA=1, ALUSrcB=10, ALUControl=ADD (forms PC+8 for R15 reads).
  - MEMADR: ALUSrcA=0, ALUSrcB=01, ADD.
  - MEMRD: AdrSrc=1.
  - MEMWB: ResultSrc=01.
    - Rd!=15: RegWrite=cond_ex_q.
    - Rd==15: PCWrite=cond_ex_q, RegWrite=0.
  - MEMWR: AdrSrc=1, MemWrite=cond_ex_q.
  - EXECR: ALUSrcA=0, ALUSrcB=00, ALUControl=decoded.
  - EXECI: same as EXECR but ALUSrcB=01.
  - ALUWB: ResultSrc=00.
    - RegWrite=cond_ex_q unless CMP or Rd==15.
    - Rd==15 and not CMP: PCWrite=cond_ex_q.
  - BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=cond_ex_q.
- Decode of cmd=Funct[4:1]:
  - 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR.
  - 1010 CMP: SUB with no register write.
  - Any other cmd: ADD, no flag write.
- FlagW rules:
  - FlagW[1] (NZ) = Funct[0] for data-processing ops.
  - FlagW[0] (CV) = Funct[0] & (ADD|SUB|CMP).
  - CMP always writes NZCV.
- Flag register update: only at the rising edge leaving EXECR/EXECI, only when cond_ex_q=1.
  - NZ <= ALUFlags[3:2] when FlagW[1].
  - CV <= ALUFlags[1:0] when FlagW[0].
- Condition evaluation:
  - Computed in DECODE from the stored flags; registered into cond_ex_q on the DECODE->next edge.
  - Codes: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
  - 1111 is treated as AL.
- cond_ex_q holds until the next DECODE, so failed-condition instructions still walk all their states with side effects suppressed.
- Flags written by instruction k are visible to the condition of instruction k+1 (its DECODE occurs after k's EXEC edge).
- ALUFlags is ignored outside EXEC states.

Test Plan:
- Reset asserted mid-MEMRD -> State=0 immediately (async), NZCV=0000; first cycle after release has IRWrite=1, PCWrite=1.
- LDR (Op=01, Funct=011001, Cond=1110) -> State sequence 0,1,2,3,4,0; RegWrite=1 only in state 4 with ResultSrc=01; MemWrite never 1.
- SUBS R1 (cmd=0010, S=1), ALUFlags=0100 in EXECR -> flags become Z=1. Following BEQ (Op=10, Cond=0000) -> PCWrite=1 in BRANCH. Following BNE -> PCWrite=0 in BRANCH, yet state still passes 9.
- CMP with ALUFlags=1000 -> ALUWB has RegWrite=0; stored N=1, Z=0. Next ADDLT (Cond=1011, V=0) -> RegWrite=1.
- STR with Cond=0001 and Z=1 (NE fails) -> states 0,1,2,5,0 with MemWrite=0 throughout. Same instruction with Z=0 -> MemWrite=1 only in state 5.
- ADD with Rd=15 -> ALUWB drives PCWrite=1, RegWrite=0. Op=11 -> states 0,1,0 with no write enables in DECODE.
